// File: rtl/mem_stage_pkg.sv
// Shared bus layouts between the EXE, MEM, WB and ID stages.
// Struct field order is MSB->LSB on the wire, so the packed structs define the offsets.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_W = 214;
    localparam int MS_TO_WS_BUS_W = 206;
    localparam int MS_FWD_BUS_W   = 39;

    // Bit positions inside ld_op {ld_b, ld_bu, ld_h, ld_hu, ld_w}
    localparam int LD_B  = 4;
    localparam int LD_BU = 3;
    localparam int LD_H  = 2;
    localparam int LD_HU = 1;
    localparam int LD_W  = 0;

    typedef struct packed {
        logic        mem_re;
        logic        mem_we;
        logic        rdcntid;
        logic [31:0] bad_addr;
        logic        has_int;
        logic [3:0]  ex_op;
        logic [31:0] rj;
        logic [31:0] rkd;
        logic [33:0] csr_data;
        logic [4:0]  ld_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        rdcntid;
        logic [31:0] bad_addr;
        logic        has_int;
        logic [3:0]  ex_op;
        logic [31:0] rj;
        logic [31:0] rkd;
        logic [33:0] csr_data;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        fwd_valid;
        logic        fwd_loading;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } ms_fwd_t;

endpackage

// File: rtl/mem_stage_align.sv
// Load data extraction: picks the addressed byte/halfword and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  ld_op,
    input  logic [1:0]  a,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;
    logic signed [31:0] byte_sext;
    logic signed [31:0] half_sext;

    always_comb begin
        byte_sel = rdata[7:0];
        case (a)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel  = a[1] ? rdata[31:16] : rdata[15:0];
        byte_sext = 32'(byte_sel);
        half_sext = 32'(half_sel);

        load_data = rdata;
        if (ld_op[LD_B])       load_data = byte_sext;
        else if (ld_op[LD_BU]) load_data = {24'd0, byte_sel};
        else if (ld_op[LD_H])  load_data = half_sext;
        else if (ld_op[LD_HU]) load_data = {16'd0, half_sel};
        else if (ld_op[LD_W])  load_data = rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data SRAM response of loads/stores, aligns load data,
// and discards responses that belong to entries killed by a WB flush.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus,
    output logic                      ms_allowin,
    input  logic                      ws_allowin,
    output logic                      ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus,
    input  logic                      data_sram_data_ok,
    input  logic [31:0]               data_sram_rdata,
    input  logic                      wb_ex,
    input  logic                      wb_ertn,
    output logic                      mem_ex,
    output logic                      mem_ertn,
    output logic                      out_ms_valid,
    output logic [MS_FWD_BUS_W-1:0]   ms_fwd_bus
);

    function automatic logic [1:0] sat_drop(input logic [1:0] cnt, input logic [1:0] up,
                                            input logic down);
        logic [2:0] sum;
        sum = {1'b0, cnt} + {1'b0, up} - {2'b00, down};
        return (sum > 3'd2) ? 2'd2 : sum[1:0];
    endfunction

    es_to_ms_t   es_in;
    es_to_ms_t   entry_p1;
    ms_to_ws_t   ms_out;
    ms_fwd_t     fwd;
    logic        vld_p1;
    logic        got_p1;
    logic [31:0] rdata_buf_p1;
    logic [1:0]  drop_cnt;

    logic        flush;
    logic        is_mem;
    logic        ok_live;
    logic        take_rdata;
    logic        ms_ready_go;
    logic        leave;
    logic        in_mem;
    logic [1:0]  drop_inc;
    logic        drop_dec;
    logic [31:0] load_word;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign es_in      = es_to_ms_bus;
    assign flush      = wb_ex | wb_ertn;
    assign is_mem     = entry_p1.mem_re | entry_p1.mem_we;
    assign ok_live    = data_sram_data_ok & (drop_cnt == 2'd0);
    assign take_rdata = vld_p1 & is_mem & ~got_p1 & ok_live;

    assign ms_ready_go    = ~is_mem | got_p1 | ok_live;
    assign ms_allowin     = ~vld_p1 | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = vld_p1 & ms_ready_go;
    assign leave          = ms_to_ws_valid & ws_allowin;
    assign in_mem         = es_to_ms_valid & ms_allowin & (es_in.mem_re | es_in.mem_we);

    // On flush, every request whose response will never be consumed is counted as owed
    assign drop_inc = flush ? (2'(vld_p1 & is_mem & ~got_p1 & ~ok_live) + 2'(in_mem)) : 2'd0;
    assign drop_dec = data_sram_data_ok & (drop_cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            got_p1   <= 1'b0;
            drop_cnt <= 2'd0;
        end else begin
            if (flush)           vld_p1 <= 1'b0;
            else if (ms_allowin) vld_p1 <= es_to_ms_valid;

            if (flush | leave)   got_p1 <= 1'b0;
            else if (take_rdata) got_p1 <= 1'b1;

            drop_cnt <= sat_drop(drop_cnt, drop_inc, drop_dec);
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid & ms_allowin & ~flush) entry_p1 <= es_in;
        if (take_rdata) rdata_buf_p1 <= data_sram_rdata;
    end

    // ---- stage p1 output: align and select result ----
    assign load_word = got_p1 ? rdata_buf_p1 : data_sram_rdata;

    load_align u_load_align (
        .ld_op     (entry_p1.ld_op),
        .a         (entry_p1.result[1:0]),
        .rdata     (load_word),
        .load_data (load_data)
    );

    assign final_result = entry_p1.res_from_mem ? load_data : entry_p1.result;

    always_comb begin
        ms_out.rdcntid      = entry_p1.rdcntid;
        ms_out.bad_addr     = entry_p1.bad_addr;
        ms_out.has_int      = entry_p1.has_int;
        ms_out.ex_op        = entry_p1.ex_op;
        ms_out.rj           = entry_p1.rj;
        ms_out.rkd          = entry_p1.rkd;
        ms_out.csr_data     = entry_p1.csr_data;
        ms_out.gr_we        = entry_p1.gr_we;
        ms_out.dest         = entry_p1.dest;
        ms_out.final_result = final_result;
        ms_out.pc           = entry_p1.pc;
    end

    assign ms_to_ws_bus = ms_out;

    assign mem_ex       = vld_p1 & ((entry_p1.ex_op != 4'd0) | entry_p1.has_int | entry_p1.csr_data[30]);
    assign mem_ertn     = vld_p1 & entry_p1.csr_data[31];
    assign out_ms_valid = vld_p1;

    assign fwd.fwd_valid    = vld_p1 & entry_p1.gr_we & (entry_p1.dest != 5'd0);
    assign fwd.fwd_loading  = fwd.fwd_valid & entry_p1.res_from_mem & ~ms_ready_go;
    assign fwd.dest         = entry_p1.dest;
    assign fwd.final_result = final_result;
    assign ms_fwd_bus       = fwd;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random traffic, with a scoreboard fed at
// handshake time and an independent monitor that checks every accepted output.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      es_to_ms_valid;
    logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus;
    logic                      ms_allowin;
    logic                      ws_allowin;
    logic                      ms_to_ws_valid;
    logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus;
    logic                      data_sram_data_ok;
    logic [31:0]               data_sram_rdata;
    logic                      wb_ex;
    logic                      wb_ertn;
    logic                      mem_ex;
    logic                      mem_ertn;
    logic                      out_ms_valid;
    logic [MS_FWD_BUS_W-1:0]   ms_fwd_bus;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_ex             (wb_ex),
        .wb_ertn           (wb_ertn),
        .mem_ex            (mem_ex),
        .mem_ertn          (mem_ertn),
        .out_ms_valid      (out_ms_valid),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    ms_to_ws_t   exp_q[$];
    logic [31:0] sram_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] next_rdata;
    logic        accepted;
    ms_to_ws_t   exp_e;
    ms_to_ws_t   act_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference load extraction written as plain shift/mask/sign arithmetic
    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        longint v;
        if (op == 5'b10000 || op == 5'b01000) begin
            v = longint'((w >> (8 * int'(a))) & 32'hFF);
            if (op == 5'b10000 && v > 127) v = v - 256;
            return 32'(v);
        end
        if (op == 5'b00100 || op == 5'b00010) begin
            v = longint'((w >> (16 * int'(a[1]))) & 32'hFFFF);
            if (op == 5'b00100 && v > 32767) v = v - 65536;
            return 32'(v);
        end
        return w;
    endfunction

    function automatic ms_to_ws_t model(input es_to_ms_t e, input logic [31:0] r);
        ms_to_ws_t m;
        m.rdcntid      = e.rdcntid;
        m.bad_addr     = e.bad_addr;
        m.has_int      = e.has_int;
        m.ex_op        = e.ex_op;
        m.rj           = e.rj;
        m.rkd          = e.rkd;
        m.csr_data     = e.csr_data;
        m.gr_we        = e.gr_we;
        m.dest         = e.dest;
        m.final_result = e.res_from_mem ? ref_load(e.ld_op, e.result[1:0], r) : e.result;
        m.pc           = e.pc;
        return m;
    endfunction

    function automatic es_to_ms_t mk(input logic re, input logic we, input logic [4:0] op,
                                     input logic [31:0] result, input logic [3:0] ex_op);
        es_to_ms_t e;
        e.mem_re       = re;
        e.mem_we       = we;
        e.rdcntid      = 1'b0;
        e.bad_addr     = $urandom;
        e.has_int      = 1'b0;
        e.ex_op        = ex_op;
        e.rj           = $urandom;
        e.rkd          = $urandom;
        e.csr_data     = 34'd0;
        e.ld_op        = op;
        e.res_from_mem = re;
        e.gr_we        = 1'b1;
        e.dest         = 5'($urandom_range(1, 31));
        e.result       = result;
        e.pc           = $urandom;
        return e;
    endfunction

    function automatic es_to_ms_t rand_entry();
        es_to_ms_t e;
        int kind;
        int k;
        kind           = $urandom_range(0, 3);
        k              = $urandom_range(0, 4);
        e.mem_re       = (kind == 1 || kind == 2);
        e.mem_we       = (kind == 3);
        e.rdcntid      = 1'($urandom);
        e.bad_addr     = $urandom;
        e.has_int      = ($urandom_range(0, 9) == 0);
        e.ex_op        = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        e.rj           = $urandom;
        e.rkd          = $urandom;
        e.csr_data     = {2'($urandom), 32'($urandom)};
        e.ld_op        = e.mem_re ? 5'(1 << k) : 5'd0;
        e.res_from_mem = e.mem_re;
        e.gr_we        = e.mem_re | (kind == 0 && $urandom_range(0, 3) != 0);
        e.dest         = 5'($urandom);
        e.result       = $urandom;
        e.pc           = $urandom;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && !(wb_ex || wb_ertn) && ms_to_ws_valid && ws_allowin) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: actual pc=%0h required no output", ms_to_ws_bus[31:0]);
            end else begin
                exp_e = exp_q.pop_front();
                act_e = ms_to_ws_bus;
                n_cmp++;
                if (act_e !== exp_e) begin
                    n_bad++;
                    $display("FAIL out_bus: actual result=%0h pc=%0h required result=%0h pc=%0h",
                             act_e.final_result, act_e.pc, exp_e.final_result, exp_e.pc);
                end
                chk("out_mem_ex", 64'(mem_ex),
                    64'((exp_e.ex_op != 4'd0) | exp_e.has_int | exp_e.csr_data[30]));
                chk("out_mem_ertn", 64'(mem_ertn), 64'(exp_e.csr_data[31]));
            end
        end
    end

    task automatic settle();
        @(negedge clk);
    endtask

    // Record the handshakes of this cycle, then advance to just after the next rising edge
    task automatic finish_cycle();
        es_to_ms_t e;
        #1;
        accepted = 1'b0;
        if (reset) begin
            exp_q.delete();
            sram_q.delete();
        end else begin
            if (wb_ex || wb_ertn) exp_q.delete();
            if (data_sram_data_ok && sram_q.size() > 0) void'(sram_q.pop_front());
            if (es_to_ms_valid && ms_allowin) begin
                e = es_to_ms_bus;
                accepted = 1'b1;
                if (e.mem_re || e.mem_we) sram_q.push_back(next_rdata);
                if (!(wb_ex || wb_ertn)) exp_q.push_back(model(e, next_rdata));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        wb_ex             = 1'b0;
        wb_ertn           = 1'b0;
    endtask

    task automatic ok_on();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = (sram_q.size() > 0) ? sram_q[0] : 32'h0;
    endtask

    task automatic accept(input es_to_ms_t e, input logic [31:0] r);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = e;
        next_rdata     = r;
        settle();
        chk("accept_allowin", 64'(ms_allowin), 64'd1);
        finish_cycle();
        es_to_ms_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_allowin"}, 64'(ms_allowin), 64'd1);
        chk({tag, "_valid"}, 64'(ms_to_ws_valid), 64'd0);
        chk({tag, "_mem_ex"}, 64'(mem_ex), 64'd0);
        chk({tag, "_mem_ertn"}, 64'(mem_ertn), 64'd0);
        chk({tag, "_out_ms_valid"}, 64'(out_ms_valid), 64'd0);
        chk({tag, "_fwd_valid"}, 64'(ms_fwd_bus[38]), 64'd0);
    endtask

    task automatic run_load(input string tag, input logic [4:0] op, input logic [31:0] res,
                            input logic [31:0] r, input logic [31:0] expect_val);
        accept(mk(1'b1, 1'b0, op, res, 4'd0), r);
        settle();
        chk({tag, "_wait_valid"}, 64'(ms_to_ws_valid), 64'd0);
        chk({tag, "_fwd_loading"}, 64'(ms_fwd_bus[37]), 64'd1);
        finish_cycle();
        ok_on();
        settle();
        chk({tag, "_ok_valid"}, 64'(ms_to_ws_valid), 64'd1);
        chk({tag, "_result"}, 64'(ms_to_ws_bus[63:32]), 64'(expect_val));
        finish_cycle();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        idle();
        es_to_ms_bus = '0;
        next_rdata   = 32'h0;
        accepted     = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        settle();
        check_idle_outputs("reset");
        finish_cycle();

        // ld_w returning two cycles after acceptance, then byte/halfword extraction
        run_load("ldw", 5'b00001, 32'h1000, 32'hDEADBEEF, 32'hDEADBEEF);
        run_load("ldb", 5'b10000, 32'h1003, 32'h80FF0011, 32'hFFFFFF80);
        run_load("ldhu", 5'b00010, 32'h1002, 32'h80FF0011, 32'h000080FF);

        // response arrives while WB stalls: value must be buffered
        accept(mk(1'b1, 1'b0, 5'b00001, 32'h2000, 4'd0), 32'h12345678);
        ws_allowin = 1'b0;
        ok_on();
        settle();
        chk("stall_ok_valid", 64'(ms_to_ws_valid), 64'd1);
        chk("stall_ok_allowin", 64'(ms_allowin), 64'd0);
        finish_cycle();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hA5A5A5A5;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_allowin", 64'(ms_allowin), 64'd0);
            chk("stall_valid", 64'(ms_to_ws_valid), 64'd1);
            finish_cycle();
        end
        ws_allowin = 1'b1;
        settle();
        chk("stall_release_result", 64'(ms_to_ws_bus[63:32]), 64'h12345678);
        finish_cycle();

        // flush while a load waits; its late response must be dropped
        accept(mk(1'b1, 1'b0, 5'b00001, 32'h3000, 4'd0), 32'h11111111);
        wb_ex = 1'b1;
        settle();
        finish_cycle();
        wb_ex          = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1'b1, 1'b0, 5'b00001, 32'h3004, 4'd0);
        next_rdata     = 32'h22222222;
        settle();
        chk("flush_out_ms_valid", 64'(out_ms_valid), 64'd0);
        chk("flush_drop_cnt", 64'(dut.drop_cnt), 64'd1);
        finish_cycle();
        es_to_ms_valid = 1'b0;
        ok_on();
        settle();
        chk("flush_stale_discarded", 64'(ms_to_ws_valid), 64'd0);
        finish_cycle();
        ok_on();
        settle();
        chk("flush_next_valid", 64'(ms_to_ws_valid), 64'd1);
        chk("flush_next_result", 64'(ms_to_ws_bus[63:32]), 64'h22222222);
        finish_cycle();
        data_sram_data_ok = 1'b0;

        // non-memory entries pass in one cycle; ex_op raises mem_ex
        accept(mk(1'b0, 1'b0, 5'd0, 32'h5, 4'd0), 32'h0);
        settle();
        chk("alu_valid", 64'(ms_to_ws_valid), 64'd1);
        chk("alu_mem_ex", 64'(mem_ex), 64'd0);
        chk("alu_result", 64'(ms_to_ws_bus[63:32]), 64'h5);
        finish_cycle();
        accept(mk(1'b0, 1'b0, 5'd0, 32'h7, 4'b0001), 32'h0);
        settle();
        chk("exop_mem_ex", 64'(mem_ex), 64'd1);
        finish_cycle();

        // reset with a load pending
        accept(mk(1'b1, 1'b0, 5'b00001, 32'h4000, 4'd0), 32'h33333333);
        reset = 1'b1;
        ok_on();
        settle();
        finish_cycle();
        reset             = 1'b0;
        data_sram_data_ok = 1'b0;
        settle();
        check_idle_outputs("rst_pending");
        chk("rst_pending_drop_cnt", 64'(dut.drop_cnt), 64'd0);
        finish_cycle();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!es_to_ms_valid || accepted) begin
                es_to_ms_valid = ($urandom_range(0, 9) < 6);
                if (es_to_ms_valid) begin
                    es_to_ms_bus = rand_entry();
                    next_rdata   = $urandom;
                end
            end
            ws_allowin = ($urandom_range(0, 9) < 7);
            if (sram_q.size() > 0 && $urandom_range(0, 1) == 1) ok_on();
            else begin
                data_sram_data_ok = 1'b0;
                data_sram_rdata   = $urandom;
            end
            wb_ex   = 1'b0;
            wb_ertn = 1'b0;
            if (sram_q.size() <= 1 && $urandom_range(0, 99) < 5) begin
                if ($urandom_range(0, 1) == 1) wb_ex = 1'b1;
                else wb_ertn = 1'b1;
            end
            settle();
            finish_cycle();
        end

        wb_ex      = 1'b0;
        wb_ertn    = 1'b0;
        ws_allowin = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0 && sram_q.size() == 0 && (!es_to_ms_valid || accepted)) break;
            if (accepted) es_to_ms_valid = 1'b0;
            if (sram_q.size() > 0) ok_on();
            else data_sram_data_ok = 1'b0;
            settle();
            finish_cycle();
        end
        data_sram_data_ok = 1'b0;
        es_to_ms_valid    = 1'b0;
        chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);
        chk("drain_responses", 64'(sram_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high.
REQ-003 SHALL have ports es_to_ms_valid in 1, es_to_ms_bus in 214, ms_allowin out 1: upstream handshake.
REQ-004 SHALL decode es_to_ms_bus MSB->LSB as mem_re1, mem_we1, rdcntid1, bad_addr32, has_int1, ex_op4, rj32, rkd32, csr_data34, ld_op5 {ld_b,ld_bu,ld_h,ld_hu,ld_w}, res_from_mem1, gr_we1, dest5, result32, pc32.
REQ-005 SHALL have ports ws_allowin in 1, ms_to_ws_valid out 1, ms_to_ws_bus out 206: downstream handshake.
REQ-006 SHALL pack ms_to_ws_bus MSB->LSB as rdcntid, bad_addr, has_int, ex_op, rj, rkd, csr_data, gr_we, dest, final_result32, pc.
REQ-007 SHALL have ports data_sram_data_ok in 1, data_sram_rdata in 32: data-return channel of the data SRAM.
REQ-008 SHALL have ports wb_ex in 1, wb_ertn in 1: flush from WB.
REQ-009 SHALL have ports mem_ex out 1, mem_ertn out 1, out_ms_valid out 1: status toward EXE.
REQ-010 SHALL have port ms_fwd_bus out 39: {fwd_valid, fwd_loading, dest5, final_result32} toward ID bypass.

Function
REQ-011 ms_valid: cleared on flush (wb_ex|wb_ertn); else on ms_allowin loads es_to_ms_valid; bus register captured when es_to_ms_valid&ms_allowin and not flushing.
REQ-012 is_mem = mem_re|mem_we of held entry; entry needs exactly one data_ok per is_mem, irrespective of ex_op.
REQ-013 data_ok arriving while ms_valid&is_mem&!got and drop_cnt==0 SHALL set got and latch data_sram_rdata into rdata_buf; got clears when entry leaves or is flushed.
REQ-014 ms_ready_go = !is_mem | got | (data_sram_data_ok & drop_cnt==0); ms_allowin = !ms_valid | ms_ready_go&ws_allowin; ms_to_ws_valid = ms_valid&ms_ready_go.
REQ-015 Load data SHALL use data_ok-cycle rdata if not yet buffered, else rdata_buf; same-cycle arrival and departure legal (zero added latency).
REQ-016 Extraction by a=result[1:0]: ld_b/ld_bu byte a sign/zero-extended; ld_h/ld_hu halfword a[1] sign/zero-extended; ld_w whole word.
REQ-017 final_result = res_from_mem ? load data : result.
REQ-018 drop_cnt (2-bit, saturate 2): on flush +1 if held entry is_mem&!got&no data_ok this cycle, +1 if es_to_ms_valid&ms_allowin with mem_re|mem_we; each data_ok with drop_cnt!=0 decrements and is discarded; simultaneous increment and decrement net.
REQ-019 mem_ex = ms_valid&(ex_op!=0|has_int|csr_data[30]); mem_ertn = ms_valid&csr_data[31].
REQ-020 fwd_valid = ms_valid&gr_we&dest!=0; fwd_loading = fwd_valid&res_from_mem&!ms_ready_go.
REQ-021 out_ms_valid = ms_valid.
REQ-022 data_ok with ms_valid=0 and drop_cnt=0 is a protocol error; SHALL be ignored.

Reset
REQ-023 reset SHALL clear ms_valid, got, drop_cnt; rdata_buf and bus register undefined-safe (no output depends on them while ms_valid=0).
REQ-024 After reset: ms_allowin=1, ms_to_ws_valid=0, mem_ex=0, mem_ertn=0, out_ms_valid=0, fwd_valid=0.
REQ-025 reset dominates flush and data_ok in same cycle.

Structure
REQ-026 Bus widths (214, 206, 39) and field offsets SHALL live in a shared package consumed by EXE, MEM, WB, ID.
REQ-027 Load extraction SHALL be one combinational sub-module, load_align (inputs ld_op, a, rdata; output 32-bit).

Verification
REQ-028 ld_w result 0x1000, data_ok two cycles later rdata 0xDEADBEEF, ws_allowin=1 -> ms_to_ws_valid in data_ok cycle, final_result 0xDEADBEEF.
REQ-029 ld_b a=3 rdata 0x80FF0011 -> 0xFFFFFF80; ld_hu a=2 same rdata -> 0x000080FF.
REQ-030 data_ok while ws_allowin=0 for 3 cycles -> rdata_buf holds value, output emitted on ws_allowin rise, ms_allowin=0 meanwhile.
REQ-031 wb_ex while load waits for data_ok -> ms_valid=0 next cycle, drop_cnt=1, next data_ok discarded, following load receives its own data.
REQ-032 non-memory add result 0x5, ex_op=0 -> passes in one cycle, mem_ex=0; entry ex_op=4'b0001 -> mem_ex=1.
REQ-033 reset asserted with load pending -> all outputs at REQ-024 values next cycle, drop_cnt=0.
